nuc_ofst_calib: RTL and testbench

- One-point (flat-field / shutter) offset calibration engine for the NUC path.
- On a start request it captures exactly one raw frame and, per pixel, computes the offset coefficient that maps `din·gain/16384 + ofst` onto a programmable target level.
- It writes the result into the coefficient memory that feeds NUC correction. It is the inverse of the correction datapath: that path consumes {gain, ofst}; this block produces ofst from din and gain.

---
 rtl/nuc_pkg.sv | 18 +
 rtl/nuc_ofst_calib_if.sv | 32 +++
 rtl/nuc_calib_mac.sv | 48 ++++
 rtl/pipeline.sv | 29 ++
 rtl/nuc_ofst_calib.sv | 150 +++++++++++++++
 tb/tb_nuc_ofst_calib.sv | 394 +++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/nuc_pkg.sv
// rtl/nuc_pkg.sv - shared NUC constants and calibration state encoding
package nuc_pkg;

  localparam int NUC_GAIN_FRAC_BITS = 14;
  localparam int NUC_UNITY_GAIN     = 16384;
  localparam int NUC_PIX_W          = 14;
  localparam int NUC_COEF_W         = 16;
  localparam int NUC_LATENCY        = 4;

  typedef enum logic [2:0] {
    CAL_IDLE,
    CAL_WAIT_SOF,
    CAL_CAPTURE,
    CAL_FLUSH,
    CAL_DONE
  } cal_state_e;

endpackage

// File: rtl/nuc_ofst_calib_if.sv
// rtl/nuc_ofst_calib_if.sv - control, pixel-in and coefficient-write bus of the offset calibration engine
interface nuc_ofst_calib_if #(
  parameter int ADDR_WIDTH = 19
) ();
  import nuc_pkg::*;

  logic                  cen;
  logic                  start;
  logic                  abort;
  logic [NUC_PIX_W-1:0]  target;
  logic                  din_sof;
  logic                  din_valid;
  logic [NUC_PIX_W-1:0]  din;
  logic [NUC_COEF_W-1:0] gain;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  coef_wr_en;
  logic [ADDR_WIDTH-1:0] coef_wr_addr;
  logic [NUC_COEF_W-1:0] coef_wr_data;

  modport master (
    output cen, start, abort, target, din_sof, din_valid, din, gain,
    input  busy, done, error, coef_wr_en, coef_wr_addr, coef_wr_data
  );

  modport slave (
    input  cen, start, abort, target, din_sof, din_valid, din, gain,
    output busy, done, error, coef_wr_en, coef_wr_addr, coef_wr_data
  );

endinterface

// File: rtl/nuc_calib_mac.sv
// rtl/nuc_calib_mac.sv - 3-stage register/multiply/subtract datapath producing ofst = target - din*gain/16384
// NUC_CALIB_ROUND_EN selects round-half-up of the product instead of truncation.
module nuc_calib_mac
  import nuc_pkg::*;
(
  input  logic                  clk,
  input  logic                  sresetn,
  input  logic                  en_i,
  input  logic [NUC_PIX_W-1:0]  din_i,
  input  logic [14:0]           gain_i,
  input  logic [NUC_PIX_W-1:0]  target_i,
  output logic [NUC_COEF_W-1:0] ofst_o
);

`ifdef NUC_CALIB_ROUND_EN
  localparam logic [29:0] RND = 30'(NUC_UNITY_GAIN / 2);
`else
  localparam logic [29:0] RND = '0;
`endif

  logic [NUC_PIX_W-1:0]  din_q;
  logic [14:0]           gain_q;
  logic [28:0]           prod_q;
  logic [NUC_COEF_W-1:0] ofst_q;
  logic [NUC_COEF_W-1:0] ofst_d;

  // Result always fits signed 16, so modulo-2^16 subtraction yields the exact bits
  always_comb begin
    ofst_d = {2'b00, target_i} - 16'(({1'b0, prod_q} + RND) >> NUC_GAIN_FRAC_BITS);
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      din_q  <= '0;
      gain_q <= '0;
      prod_q <= '0;
      ofst_q <= '0;
    end else if (en_i) begin
      din_q  <= din_i;
      gain_q <= gain_i;
      prod_q <= 29'(din_q) * 29'(gain_q);
      ofst_q <= ofst_d;
    end
  end

  assign ofst_o = ofst_q;

endmodule

// File: rtl/pipeline.sv
// rtl/pipeline.sv - clock-enabled delay line with synchronous clear
module pipeline #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             sresetn,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/nuc_ofst_calib.sv
// rtl/nuc_ofst_calib.sv - one-point offset calibration: captures one frame and writes a per-pixel offset
// Optional NUC_CALIB_ROUND_EN (in nuc_calib_mac) rounds the gain product instead of truncating.
module nuc_ofst_calib
  import nuc_pkg::*;
#(
  parameter int FRAME_PIXELS = 327680,
  parameter int ADDR_WIDTH   = 19
) (
  input  logic            clk,
  input  logic            sresetn,
  nuc_ofst_calib_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(FRAME_PIXELS - 1);
  localparam logic [1:0]            FLUSH_LAST = 2'(NUC_LATENCY - 1);
  localparam int                    PW         = ADDR_WIDTH + 2;

  cal_state_e            state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic [NUC_PIX_W-1:0]  target_q;
  logic [ADDR_WIDTH-1:0] pix_cnt_q;
  logic [1:0]            flush_cnt_q;

  logic                  accept;
  logic                  short_frame;
  logic                  pipe_clr;
  logic [ADDR_WIDTH-1:0] pix_addr;

  logic [PW-1:0]         pipe_q;
  logic                  v3;
  logic                  g3;
  logic [ADDR_WIDTH-1:0] a3;
  logic [NUC_COEF_W-1:0] ofst;

  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [NUC_COEF_W-1:0] wr_data_q;

  always_comb begin
    short_frame = (state_q == CAL_CAPTURE) && bus.din_valid && bus.din_sof && !bus.abort;
    accept      = !bus.abort && bus.din_valid &&
                  (((state_q == CAL_WAIT_SOF) && bus.din_sof) ||
                   ((state_q == CAL_CAPTURE) && !bus.din_sof));
    pix_addr    = (state_q == CAL_CAPTURE) ? pix_cnt_q : '0;
    pipe_clr    = bus.cen && (bus.abort || short_frame);
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q     <= CAL_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      target_q    <= '0;
      pix_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else if (bus.cen) begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (bus.abort) begin
        state_q <= CAL_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          CAL_IDLE: begin
            if (bus.start) begin
              state_q  <= CAL_WAIT_SOF;
              busy_q   <= 1'b1;
              target_q <= bus.target;
            end
          end
          CAL_WAIT_SOF, CAL_CAPTURE: begin
            if (short_frame) begin
              state_q <= CAL_IDLE;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else if (accept) begin
              pix_cnt_q   <= pix_addr + ADDR_WIDTH'(1);
              flush_cnt_q <= '0;
              state_q     <= (pix_addr == LAST_IDX) ? CAL_FLUSH : CAL_CAPTURE;
            end
          end
          CAL_FLUSH: begin
            flush_cnt_q <= flush_cnt_q + 2'd1;
            // done lands one cycle after the final write leaves the output register
            if (flush_cnt_q == FLUSH_LAST) begin
              state_q <= CAL_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          CAL_DONE: state_q <= CAL_IDLE;
          default:  state_q <= CAL_IDLE;
        endcase
      end
    end
  end

  pipeline #(
    .WIDTH (PW),
    .DEPTH (NUC_LATENCY - 1)
  ) u_ctl_pipe (
    .clk     (clk),
    .sresetn (sresetn),
    .en_i    (bus.cen),
    .clr_i   (pipe_clr),
    .d_i     ({accept, pix_addr, bus.gain[15]}),
    .q_o     (pipe_q)
  );

  assign v3 = pipe_q[PW-1];
  assign a3 = pipe_q[PW-2:1];
  assign g3 = pipe_q[0];

  nuc_calib_mac u_mac (
    .clk      (clk),
    .sresetn  (sresetn),
    .en_i     (bus.cen),
    .din_i    (bus.din),
    .gain_i   (bus.gain[14:0]),
    .target_i (target_q),
    .ofst_o   (ofst)
  );

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (pipe_clr) begin
      wr_en_q <= 1'b0;
    end else if (bus.cen) begin
      wr_en_q <= v3;
      if (v3) begin
        wr_addr_q <= a3;
        wr_data_q <= g3 ? ofst : '0;
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.coef_wr_en   = wr_en_q;
  assign bus.coef_wr_addr = wr_addr_q;
  assign bus.coef_wr_data = wr_data_q;

endmodule

// File: tb/tb_nuc_ofst_calib.sv
// tb/tb_nuc_ofst_calib.sv - randomized self-checking bench for nuc_ofst_calib against an arithmetic offset model
module tb_nuc_ofst_calib;

  localparam int FP = 200;
  localparam int AW = 8;

  logic clk     = 1'b0;
  logic sresetn = 1'b0;
  always #5 clk = ~clk;

  nuc_ofst_calib_if #(.ADDR_WIDTH(AW)) bus ();

  nuc_ofst_calib #(.FRAME_PIXELS(FP), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .sresetn (sresetn),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/pulse monitor: a strobe counts once, on a cycle where the enable lets the memory take it
  logic [AW-1:0] wr_addr_q [$];
  logic [15:0]   wr_data_q [$];
  int done_cnt, error_cnt, first_wr_cyc, last_wr_cyc, done_cyc, take_cyc, sof_cyc;

  always @(negedge clk) begin
    if (sresetn && bus.cen) begin
      if (bus.coef_wr_en) begin
        wr_addr_q.push_back(bus.coef_wr_addr);
        wr_data_q.push_back(bus.coef_wr_data);
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.error) error_cnt++;
    end
  end

  logic [13:0] din_a  [FP];
  logic [15:0] gain_a [FP];
  int          tgt;
  bit          cen_toggle;

  function automatic logic [15:0] exp_data(input int i);
    longint p, c;
    if (!gain_a[i][15]) return 16'h0000;
    p = longint'(din_a[i]) * longint'(gain_a[i][14:0]);
`ifdef NUC_CALIB_ROUND_EN
    c = (p + 8192) / 16384;
`else
    c = p / 16384;
`endif
    return 16'(longint'(tgt) - c);
  endfunction

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0; error_cnt = 0;
    first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
  endtask

  task automatic fill_const(input logic [13:0] d, input logic [15:0] g);
    for (int i = 0; i < FP; i++) begin
      din_a[i]  = d;
      gain_a[i] = g;
    end
  endtask

  task automatic fill_rand(input int bad_pct);
    for (int i = 0; i < FP; i++) begin
      din_a[i]  = 14'($urandom);
      gain_a[i] = {($urandom_range(99) >= 32'(bad_pct)), 15'($urandom)};
    end
  endtask

  // Present one input cycle; with cen toggling, hold it until an enabled cycle consumes it
  task automatic drive(input logic v, input logic sof, input logic [13:0] d, input logic [15:0] g);
    bit taken = 1'b0;
    while (!taken) begin
      bus.din_valid = v;
      bus.din_sof   = sof;
      bus.din       = d;
      bus.gain      = g;
      bus.cen       = cen_toggle ? ~bus.cen : 1'b1;
      taken         = bus.cen;
      take_cyc      = cyc;
      @(posedge clk);
      #1;
    end
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) drive(1'b0, 1'b0, 14'd0, 16'd0);
  endtask

  task automatic do_start(input int t);
    tgt        = t;
    bus.target = 14'(t);
    bus.start  = 1'b1;
    drive(1'b0, 1'b0, 14'd0, 16'd0);
    bus.start  = 1'b0;
  endtask

  task automatic run_frame(input int stop_at, input int sof_at, input int abort_at,
                           input int start_at, input int gap_pct);
    for (int i = 0; i < FP; i++) begin
      if (i == stop_at) return;
      if (i > 0 && $urandom_range(99) < 32'(gap_pct)) drive(1'b0, 1'b0, 14'd0, 16'd0);
      bus.start = (i == start_at);
      bus.abort = (i == abort_at);
      drive(1'b1, (i == 0) || (i == sof_at), din_a[i], gain_a[i]);
      if (i == 0) sof_cyc = take_cyc;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (i == abort_at || i == sof_at) return;
    end
  endtask

  task automatic test_reset();
    bus.cen = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.target = '0;
    bus.din_sof = 1'b0; bus.din_valid = 1'b0; bus.din = '0; bus.gain = '0;
    cen_toggle = 1'b0;
    clear_mon();
    sresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.error, bus.coef_wr_en, bus.coef_wr_addr, bus.coef_wr_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_held: busy %b done %b error %b en %b addr %h data %h, expected all 0",
               bus.busy, bus.done, bus.error, bus.coef_wr_en, bus.coef_wr_addr, bus.coef_wr_data);
    end
    sresetn = 1'b1;
    settle(3);
    vectors++;
    if ({bus.busy, bus.done, bus.error, bus.coef_wr_en} !== 4'b0 || wr_addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_idle: busy %b done %b error %b en %b writes %0d, expected 0",
               bus.busy, bus.done, bus.error, bus.coef_wr_en, wr_addr_q.size());
    end
  endtask

  task automatic test_unity();
    clear_mon();
    cen_toggle = 1'b0;
    fill_const(14'd5000, 16'hC000);
    do_start(8000);
    run_frame(-1, -1, -1, 10, 0);
    settle(10);
    vectors++;
    if (wr_addr_q.size() != FP) begin
      miscompares++;
      $display("FAIL unity_count: got %0d writes, expected %0d", wr_addr_q.size(), FP);
    end
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      vectors++;
      if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== 16'h0BB8 || exp_data(i) !== 16'h0BB8) begin
        miscompares++;
        $display("FAIL unity_wr[%0d]: addr %0d data %h, expected addr %0d data 0bb8", i, wr_addr_q[i], wr_data_q[i], i);
      end
    end
    vectors++;
    if (first_wr_cyc - sof_cyc != 4) begin
      miscompares++;
      $display("FAIL unity_latency: got %0d cycles, expected 4", first_wr_cyc - sof_cyc);
    end
    vectors++;
    if (done_cnt != 1 || error_cnt != 0 || done_cyc != last_wr_cyc + 1) begin
      miscompares++;
      $display("FAIL unity_done: done %0d error %0d done_cyc %0d last_wr %0d, expected 1/0/last+1",
               done_cnt, error_cnt, done_cyc, last_wr_cyc);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL unity_busy: got %b, expected 0 (mid-frame start must not rearm)", bus.busy);
    end
  endtask

  task automatic test_bad_pixel();
    clear_mon();
    cen_toggle = 1'b0;
    fill_rand(0);
    gain_a[7] = 16'h4000;
    do_start(int'($urandom_range(16383)));
    run_frame(-1, -1, -1, -1, 20);
    settle(10);
    vectors++;
    if (wr_addr_q.size() != FP || done_cnt != 1) begin
      miscompares++;
      $display("FAIL bad_count: writes %0d done %0d, expected %0d/1", wr_addr_q.size(), done_cnt, FP);
    end
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      vectors++;
      if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_data(i)) begin
        miscompares++;
        $display("FAIL bad_wr[%0d]: addr %0d data %h, expected addr %0d data %h", i, wr_addr_q[i], wr_data_q[i], i, exp_data(i));
      end
    end
    vectors++;
    if (wr_data_q.size() > 7 && wr_data_q[7] !== 16'h0000) begin
      miscompares++;
      $display("FAIL bad_px7: got %h, expected 0000", wr_data_q[7]);
    end
  endtask

  task automatic test_extremes();
    clear_mon();
    cen_toggle = 1'b0;
    fill_const(14'h3FFF, 16'hFFFF);
    do_start(0);
    run_frame(-1, -1, -1, -1, 0);
    settle(10);
    vectors++;
    if (wr_addr_q.size() != FP || done_cnt != 1) begin
      miscompares++;
      $display("FAIL ext_count: writes %0d done %0d, expected %0d/1", wr_addr_q.size(), done_cnt, FP);
    end
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      vectors++;
      if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_data(i)) begin
        miscompares++;
        $display("FAIL ext_wr[%0d]: addr %0d data %h, expected addr %0d data %h", i, wr_addr_q[i], wr_data_q[i], i, exp_data(i));
      end
    end
  endtask

  task automatic test_short_frame();
    clear_mon();
    cen_toggle = 1'b0;
    fill_rand(10);
    do_start(int'($urandom_range(16383)));
    run_frame(-1, 100, -1, -1, 0);
    settle(20);
    vectors++;
    if (error_cnt != 1 || done_cnt != 0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL short_status: error %0d done %0d busy %b, expected 1/0/0", error_cnt, done_cnt, bus.busy);
    end
    vectors++;
    if (wr_addr_q.size() > 100 || wr_addr_q.size() == 0) begin
      miscompares++;
      $display("FAIL short_count: got %0d writes, expected 1..100", wr_addr_q.size());
    end
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      vectors++;
      if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_data(i)) begin
        miscompares++;
        $display("FAIL short_wr[%0d]: addr %0d data %h, expected addr %0d data %h", i, wr_addr_q[i], wr_data_q[i], i, exp_data(i));
      end
    end
  endtask

  task automatic test_abort_cen();
    int n;
    clear_mon();
    cen_toggle = 1'b1;
    fill_rand(10);
    do_start(int'($urandom_range(16383)));
    run_frame(-1, -1, 50, -1, 0);
    n = wr_addr_q.size();
    settle(20);
    vectors++;
    if (wr_addr_q.size() != n || n > 50 || done_cnt != 0 || error_cnt != 0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_status: writes %0d->%0d done %0d error %0d busy %b, expected no growth/0/0/0",
               n, wr_addr_q.size(), done_cnt, error_cnt, bus.busy);
    end
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      vectors++;
      if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_data(i)) begin
        miscompares++;
        $display("FAIL abort_wr[%0d]: addr %0d data %h, expected addr %0d data %h", i, wr_addr_q[i], wr_data_q[i], i, exp_data(i));
      end
    end
    clear_mon();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    drive(1'b0, 1'b0, 14'd0, 16'd0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    drive(1'b1, 1'b1, 14'd100, 16'hC000);
    settle(10);
    vectors++;
    if (bus.busy !== 1'b0 || wr_addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_start_same: busy %b writes %0d, expected 0/0", bus.busy, wr_addr_q.size());
    end
    clear_mon();
    fill_rand(10);
    do_start(int'($urandom_range(16383)));
    run_frame(-1, -1, -1, -1, 0);
    settle(20);
    vectors++;
    if (wr_addr_q.size() != FP || done_cnt != 1 || error_cnt != 0) begin
      miscompares++;
      $display("FAIL abort_rerun: writes %0d done %0d error %0d, expected %0d/1/0", wr_addr_q.size(), done_cnt, error_cnt, FP);
    end
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      vectors++;
      if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_data(i)) begin
        miscompares++;
        $display("FAIL rerun_wr[%0d]: addr %0d data %h, expected addr %0d data %h", i, wr_addr_q[i], wr_data_q[i], i, exp_data(i));
      end
    end
    cen_toggle = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    clear_mon();
    cen_toggle = 1'b0;
    fill_rand(0);
    do_start(int'($urandom_range(16383)));
    run_frame(60, -1, -1, -1, 0);
    vectors++;
    if (bus.busy !== 1'b1 || bus.coef_wr_en !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_active: busy %b en %b, expected 1/1", bus.busy, bus.coef_wr_en);
    end
    #2 sresetn = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.error, bus.coef_wr_en, bus.coef_wr_addr, bus.coef_wr_data} !== '0) begin
      miscompares++;
      $display("FAIL midrst_async: busy %b done %b error %b en %b addr %h data %h, expected all 0",
               bus.busy, bus.done, bus.error, bus.coef_wr_en, bus.coef_wr_addr, bus.coef_wr_data);
    end
    @(posedge clk);
    #1 sresetn = 1'b1;
    n = wr_addr_q.size();
    run_frame(-1, -1, -1, -1, 0);
    settle(10);
    vectors++;
    if (wr_addr_q.size() != n || bus.busy !== 1'b0 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL midrst_after: writes %0d->%0d busy %b done %0d, expected no writes/0/0",
               n, wr_addr_q.size(), bus.busy, done_cnt);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 2; f++) begin
      clear_mon();
      cen_toggle = (f == 1);
      fill_rand(15);
      do_start(int'($urandom_range(16383)));
      run_frame(-1, -1, -1, -1, 25);
      settle(20);
      vectors++;
      if (wr_addr_q.size() != FP || done_cnt != 1 || error_cnt != 0) begin
        miscompares++;
        $display("FAIL rand%0d_count: writes %0d done %0d error %0d, expected %0d/1/0", f, wr_addr_q.size(), done_cnt, error_cnt, FP);
      end
      for (int i = 0; i < wr_addr_q.size(); i++) begin
        vectors++;
        if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_data(i)) begin
          miscompares++;
          $display("FAIL rand%0d_wr[%0d]: addr %0d data %h, expected addr %0d data %h", f, i, wr_addr_q[i], wr_data_q[i], i, exp_data(i));
        end
      end
    end
    cen_toggle = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unity();
    test_bad_pixel();
    test_extremes();
    test_short_frame();
    test_abort_cen();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
